// File: rtl/mem_port_arbiter.sv
// Three-way round-robin arbiter for the single-port data/instruction memory.
// One registered access per cycle; read data or out-of-range error returned one cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [2:0]          req_i,
    input  logic [2:0]          we_i,
    input  logic [3*ADDR_W-1:0] addr_i,
    input  logic [3*DATA_W-1:0] wdata_i,
    input  logic                lock_i,
    output logic [2:0]          gnt_o,
    output logic [2:0]          rvalid_o,
    output logic [2:0]          err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

    logic [2:0]        gnt_q, gnt_d;
    logic [1:0]        last_q, last_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        rvalid_q, rvalid_d;
    logic [2:0]        err_q, err_d;
    logic              rsp_ok_q, rsp_ok_d;

    logic [2:0]        elig;
    logic [1:0]        cand1, cand2;
    logic [1:0]        win;
    logic              win_vld;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_in_range;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // A requester is never re-granted in its own grant cycle; lock restricts to the host port.
    always_comb begin
        elig = req_i & ~gnt_q;
        if (lock_i) begin
            elig = elig & 3'b001;
        end
    end

    assign cand1 = rr_next(last_q);
    assign cand2 = rr_next(cand1);

    always_comb begin
        win_vld = 1'b1;
        win     = last_q;
        if (elig[cand1]) begin
            win = cand1;
        end else if (elig[cand2]) begin
            win = cand2;
        end else if (elig[last_q]) begin
            win = last_q;
        end else begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        win_we       = we_i[win];
        win_addr     = addr_i[win*ADDR_W +: ADDR_W];
        win_wdata    = wdata_i[win*DATA_W +: DATA_W];
        win_in_range = ({1'b0, win_addr} < DEPTH_C);
    end

    // Grant stage: register winner and drive the memory port.
    always_comb begin
        gnt_d       = 3'b000;
        last_d      = last_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (win_vld) begin
            gnt_d       = 3'b001 << win;
            last_d      = win;
            mem_en_d    = win_in_range;
            mem_we_d    = win_we;
            mem_addr_d  = win_addr;
            mem_wdata_d = win_wdata;
        end
    end

    // Response stage: follows the grant by one cycle, aligned with the memory's read data.
    always_comb begin
        rvalid_d = mem_we_q  ? 3'b000 : gnt_q;
        err_d    = mem_en_q  ? 3'b000 : gnt_q;
        rsp_ok_d = mem_en_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q       <= 3'b000;
            last_q      <= 2'd2;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= 3'b000;
            err_q       <= 3'b000;
            rsp_ok_q    <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rsp_ok_q    <= rsp_ok_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = ((rvalid_q != 3'b000) && rsp_ok_q) ? mem_rdata_i : '0;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-port 32-bit data/instruction memory among three requesters: host/debug port (0), execute-stage load/store (1) and instruction fetch (2). Round-robin grant with a host lock override, one registered memory access per cycle, and read data returned one cycle after issue. Sits between the processor's fetch/execute/writeback sequencing and the memory array, replacing direct `mem[]` indexing.

## Interface
- `ADDR_W`, 12, address width (matches 12-bit instruction address fields)
- `DATA_W`, 32, data word width
- `MEM_DEPTH`, 16, number of implemented words; addresses >= MEM_DEPTH are out of range

- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  3  per-requester access request, bit i = requester i
- `we`  in  3  per-requester write enable, 1 = write, 0 = read
- `addr`  in  3*ADDR_W  requester i address at `[i*ADDR_W +: ADDR_W]`
- `wdata`  in  3*DATA_W  requester i write data at `[i*DATA_W +: DATA_W]`
- `lock`  in  1  host lock; while high only requester 0 is eligible
- `gnt`  out  3  one-hot, one-cycle grant pulse
- `rvalid`  out  3  one-hot, one-cycle read-data-valid pulse
- `err`  out  3  one-hot, one-cycle out-of-range pulse
- `rdata`  out  DATA_W  shared read data, qualified by `rvalid`
- `mem_en`  out  1  memory access enable
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  synchronous memory read data, valid the cycle after `mem_en`

## Operation
- Eligible set E = `req` & ~`gnt` (a requester cannot be re-granted in its own grant cycle); if `lock`, E = E & 3'b001.
- Round-robin: 2-bit `last` pointer holds last granted index; search order starts at (last+1) mod 3. Reset `last` = 2, so requester 0 wins first contention.
- Winner w: `gnt[w]` registered high one cycle; `last` <= w; `mem_addr`/`mem_we`/`mem_wdata` <= w's inputs; `mem_en` <= 1 if addr(w) < MEM_DEPTH, else 0.
- No eligible requester: `gnt` = 0, `mem_en` = 0, `mem_we` = 0, `mem_addr`/`mem_wdata` hold.
- Response stage (one cycle after grant, pipelined): in-range read -> `rvalid[w]` = 1, `rdata` = `mem_rdata`; in-range write -> no response pulse; out-of-range read or write -> `err[w]` = 1, and for reads also `rvalid[w]` = 1 with `rdata` = 0.
- `rdata` = 0 whenever no `rvalid` bit is set.
- Requester rules: hold `req`, `we`, `addr`, `wdata` stable until `gnt` seen; `req` still high in the cycle after `gnt` is a new request.
- `lock` rising while requester 1 or 2 has an access in the response stage: that response still delivered. `lock` never aborts a grant already issued.
- Simultaneous grant and response to different requesters allowed every cycle (full throughput one access/cycle across requesters; max one access per two cycles per requester).

## Timing
- Reset (`rst_n` low, async): `gnt`, `rvalid`, `err` = 0; `rdata` = 0; `mem_en`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0; `last` = 2; response stage cleared. Reset mid-access drops the pending response; no `rvalid` after deassertion.
- Cycle 0 `req[i]` high -> edge 1: `gnt[i]`, `mem_en` high during cycle 1 -> memory captures at edge 2 -> `rvalid[i]`/`rdata` (or `err[i]`) during cycle 2. Read latency = 2 cycles from request, 1 from grant.
- Worst-case wait for an eligible, unlocked requester under full contention: 2 grants to others (3 cycles req-to-gnt).
- Write to address A granted cycle n, read of A granted cycle n+1 returns new data (memory write-first is not required; access order preserved).

## Test plan
- Single read: mem[3]=32'h10000000, req=3'b100, addr(2)=3 -> gnt=3'b100 cycle 1, rvalid=3'b100, rdata=32'h10000000 cycle 2.
- Full contention: req=3'b111 held (re-asserted after each gnt), all reads -> grant order 0,1,2,0,1,2; each rvalid one cycle after its gnt; no idle memory cycle.
- Write then read: requester 1 writes 32'h00000003 to addr 1, then requester 0 reads addr 1 -> rdata=32'h00000003, err=0.
- Out of range: requester 2 read addr 12'h010 (MEM_DEPTH=16) -> gnt[2], mem_en=0, next cycle err=3'b100, rvalid=3'b100, rdata=0; write to 12'hFFF -> err pulse, no rvalid, memory unchanged.
- Lock: lock=1, req=3'b110 for 5 cycles -> gnt=0; req[0] pulse -> gnt[0] granted; lock=0 -> requester 1 then 2 granted.
- Async reset mid-read: rst_n low between gnt and response -> all outputs 0 immediately, no rvalid after release, first grant after release goes to requester 0 under contention.
